// File: rtl/amstrad_audio_mixer.sv
// Time-multiplexed stereo mixer: per-channel 4-bit L/R gains, serial MAC, saturation; result NCH+1 clks after capture.
// No backpressure: a ce arriving mid-accumulation is dropped and flagged on overrun; a ce in DONE is accepted back-to-back.
`timescale 1ns/1ps
module amstrad_audio_mixer #(
  parameter int              NCH        = 3,
  parameter int              IN_W       = 8,
  parameter int              OUT_W      = 8,
  parameter logic [NCH*4-1:0] DEF_GAIN_L = {4'd0, 4'd4, 4'd8},
  parameter logic [NCH*4-1:0] DEF_GAIN_R = {4'd8, 4'd4, 4'd0}
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                ce,
  input  logic [NCH*IN_W-1:0] ch_in,
  input  logic                mute,
  input  logic                cfg_we,
  input  logic [3:0]          cfg_ch,
  input  logic [3:0]          cfg_gl,
  input  logic [3:0]          cfg_gr,
  output logic [OUT_W-1:0]    audio_l,
  output logic [OUT_W-1:0]    audio_r,
  output logic                valid,
  output logic                busy,
  output logic                overrun
);

  localparam int ACC_W = IN_W + 4 + $clog2(NCH + 1);
  localparam int IDX_W = 4;
  localparam int SAT_W = ACC_W + OUT_W;

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t              state_q, state_d;
  logic [NCH*4-1:0]    gl_q, gl_d, gr_q, gr_d;
  logic [NCH*4-1:0]    sgl_q, sgl_d, sgr_q, sgr_d;
  logic [NCH*IN_W-1:0] snap_q, snap_d;
  logic                mute_q, mute_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [ACC_W-1:0]    acc_l_q, acc_l_d, acc_r_q, acc_r_d;
  logic [OUT_W-1:0]    audio_l_q, audio_l_d, audio_r_q, audio_r_d;
  logic                valid_q, valid_d;
  logic                overrun_q, overrun_d;
  logic [IN_W+3:0]     prod_l, prod_r;

  function automatic logic [OUT_W-1:0] sat(input logic [ACC_W-1:0] acc);
    logic [SAT_W-1:0] v;
    v = SAT_W'(acc >> 4);
    if (v > SAT_W'({OUT_W{1'b1}}))
      sat = '1;
    else
      sat = v[OUT_W-1:0];
  endfunction

  // Snapshot and shadow gains shift down each ACC cycle, so the MAC always reads the low slot.
  assign prod_l = (IN_W+4)'(snap_q[IN_W-1:0]) * (IN_W+4)'(sgl_q[3:0]);
  assign prod_r = (IN_W+4)'(snap_q[IN_W-1:0]) * (IN_W+4)'(sgr_q[3:0]);

  always_comb begin
    state_d   = state_q;
    gl_d      = gl_q;
    gr_d      = gr_q;
    sgl_d     = sgl_q;
    sgr_d     = sgr_q;
    snap_d    = snap_q;
    mute_d    = mute_q;
    idx_d     = idx_q;
    acc_l_d   = acc_l_q;
    acc_r_d   = acc_r_q;
    audio_l_d = audio_l_q;
    audio_r_d = audio_r_q;
    valid_d   = 1'b0;
    overrun_d = 1'b0;

    for (int k = 0; k < NCH; k++) begin
      if (cfg_we && (cfg_ch == 4'(k))) begin
        gl_d[4*k +: 4] = cfg_gl;
        gr_d[4*k +: 4] = cfg_gr;
      end
    end

    case (state_q)
      IDLE: begin
        if (ce) begin
          snap_d  = ch_in;
          mute_d  = mute;
          sgl_d   = gl_q;
          sgr_d   = gr_q;
          acc_l_d = '0;
          acc_r_d = '0;
          idx_d   = '0;
          state_d = ACC;
        end
      end
      ACC: begin
        acc_l_d   = acc_l_q + ACC_W'(prod_l);
        acc_r_d   = acc_r_q + ACC_W'(prod_r);
        snap_d    = snap_q >> IN_W;
        sgl_d     = sgl_q >> 4;
        sgr_d     = sgr_q >> 4;
        overrun_d = ce;
        if (idx_q == IDX_W'(NCH - 1))
          state_d = DONE;
        else
          idx_d = idx_q + IDX_W'(1);
      end
      DONE: begin
        audio_l_d = mute_q ? '0 : sat(acc_l_q);
        audio_r_d = mute_q ? '0 : sat(acc_r_q);
        valid_d   = 1'b1;
        state_d   = IDLE;
        // A ce landing on the result edge starts the next sample without an idle gap.
        if (ce) begin
          snap_d  = ch_in;
          mute_d  = mute;
          sgl_d   = gl_q;
          sgr_d   = gr_q;
          acc_l_d = '0;
          acc_r_d = '0;
          idx_d   = '0;
          state_d = ACC;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      gl_q      <= DEF_GAIN_L;
      gr_q      <= DEF_GAIN_R;
      sgl_q     <= '0;
      sgr_q     <= '0;
      snap_q    <= '0;
      mute_q    <= 1'b0;
      idx_q     <= '0;
      acc_l_q   <= '0;
      acc_r_q   <= '0;
      audio_l_q <= '0;
      audio_r_q <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gl_q      <= gl_d;
      gr_q      <= gr_d;
      sgl_q     <= sgl_d;
      sgr_q     <= sgr_d;
      snap_q    <= snap_d;
      mute_q    <= mute_d;
      idx_q     <= idx_d;
      acc_l_q   <= acc_l_d;
      acc_r_q   <= acc_r_d;
      audio_l_q <= audio_l_d;
      audio_r_q <= audio_r_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign audio_l = audio_l_q;
  assign audio_r = audio_r_q;
  assign valid   = valid_q;
  assign overrun = overrun_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_amstrad_audio_mixer.sv
// Directed bench for amstrad_audio_mixer (NCH=3, 8-bit in/out); expected values hand-computed.
`timescale 1ns/1ps
module tb_amstrad_audio_mixer;
  localparam int NCH = 3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ce = 1'b0;
  logic [23:0] ch_in = '0;
  logic        mute = 1'b0;
  logic        cfg_we = 1'b0;
  logic [3:0]  cfg_ch = '0;
  logic [3:0]  cfg_gl = '0;
  logic [3:0]  cfg_gr = '0;
  logic [7:0]  audio_l, audio_r;
  logic        valid, busy, overrun;

  int errors = 0;
  int checks = 0;

  amstrad_audio_mixer dut (
    .clk(clk), .reset_n(reset_n), .ce(ce), .ch_in(ch_in), .mute(mute),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_gl(cfg_gl), .cfg_gr(cfg_gr),
    .audio_l(audio_l), .audio_r(audio_r), .valid(valid), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_gain(input logic [3:0] ch, input logic [3:0] gl, input logic [3:0] gr);
    cfg_we = 1'b1; cfg_ch = ch; cfg_gl = gl; cfg_gr = gr;
    step();
    cfg_we = 1'b0;
  endtask

  // Capture edge happens inside; returns 1ns after it with mute already released.
  task automatic start(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic m);
    ch_in = {c, b, a}; mute = m; ce = 1'b1;
    step();
    ce = 1'b0; mute = 1'b0;
  endtask

  task automatic result(input string tag, input int l, input int r);
    int early;
    early = 0;
    chk({tag, "_busy"}, busy, 1);
    repeat (NCH) begin
      step();
      if (valid) early++;
    end
    chk({tag, "_early_valid"}, early, 0);
    step();
    chk({tag, "_valid"}, valid, 1);
    chk({tag, "_l"}, audio_l, l);
    chk({tag, "_r"}, audio_r, r);
    step();
    chk({tag, "_valid_drop"}, valid, 0);
    chk({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    int cnt;

    // Reset held for two edges
    step(); step();
    chk("rst_l", audio_l, 0);
    chk("rst_r", audio_r, 0);
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    reset_n = 1'b1;
    step();

    // Defaults: L = (A*8 + B*4) >> 4, R = (C*8 + B*4) >> 4 on the exact sum
    start(8'hFF, 8'hFF, 8'hFF, 1'b0);
    result("def_ff", 191, 191);
    start(8'd100, 8'd40, 8'd200, 1'b0);
    result("def_mix", 60, 110);

    // Out-of-range channel index must leave all gains untouched
    set_gain(4'd3, 4'd15, 4'd15);
    start(8'd100, 8'd40, 8'd200, 1'b0);
    result("cfg_oob", 60, 110);

    // Gain write on the capture edge: this sample keeps gl0=8, next uses 15
    ch_in = {8'd0, 8'd0, 8'd16};
    cfg_we = 1'b1; cfg_ch = 4'd0; cfg_gl = 4'd15; cfg_gr = 4'd0; ce = 1'b1;
    step();
    cfg_we = 1'b0; ce = 1'b0;
    result("race_old", 8, 0);
    start(8'd16, 8'd0, 8'd0, 1'b0);
    result("race_new", 15, 0);

    // Saturation with all gains 15
    set_gain(4'd0, 4'd15, 4'd15);
    set_gain(4'd1, 4'd15, 4'd15);
    set_gain(4'd2, 4'd15, 4'd15);
    start(8'hFF, 8'hFF, 8'hFF, 1'b0);
    result("sat_full", 255, 255);
    start(8'd255, 8'd19, 8'd0, 1'b0);   // 274*15 = 4110, >>4 = 256
    result("sat_edge", 255, 255);
    start(8'd255, 8'd18, 8'd0, 1'b0);   // 273*15 = 4095, >>4 = 255
    result("sat_exact", 255, 255);
    start(8'd100, 8'd0, 8'd0, 1'b0);    // 1500 >> 4 = 93
    result("gain15", 93, 93);

    // Overrun: second ce two clocks after the first is dropped
    start(8'd10, 8'd10, 8'd10, 1'b0);   // 450 >> 4 = 28
    step();
    ch_in = {8'd255, 8'd255, 8'd255}; ce = 1'b1;
    step();
    ce = 1'b0;
    chk("ovr_pulse", overrun, 1);
    step();
    chk("ovr_drop", overrun, 0);
    chk("ovr_early_valid", valid, 0);
    step();
    chk("ovr_valid", valid, 1);
    chk("ovr_l", audio_l, 28);
    chk("ovr_r", audio_r, 28);
    cnt = 0;
    repeat (6) begin
      step();
      if (valid || overrun) cnt++;
    end
    chk("ovr_no_second", cnt, 0);
    chk("ovr_idle", busy, 0);

    // Back-to-back: ce on the DONE edge is accepted
    start(8'd10, 8'd10, 8'd10, 1'b0);
    repeat (NCH) step();
    ch_in = {8'd20, 8'd20, 8'd20}; ce = 1'b1;
    step();
    ce = 1'b0;
    chk("b2b_valid1", valid, 1);
    chk("b2b_l1", audio_l, 28);
    chk("b2b_ovr", overrun, 0);
    result("b2b_2", 56, 56);           // 900 >> 4 = 56

    // Mute is sampled at capture only
    start(8'hFF, 8'hFF, 8'hFF, 1'b1);
    result("mute", 0, 0);
    start(8'd100, 8'd0, 8'd0, 1'b0);
    result("unmute", 93, 93);

    // Reset during ACC: no result, outputs cleared, gains back to defaults
    start(8'hFF, 8'hFF, 8'hFF, 1'b0);
    step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_l", audio_l, 0);
    chk("mid_rst_r", audio_r, 0);
    cnt = 0;
    repeat (6) begin
      step();
      if (valid) cnt++;
    end
    chk("mid_rst_no_valid", cnt, 0);
    chk("mid_rst_l_hold", audio_l, 0);
    start(8'hFF, 8'hFF, 8'hFF, 1'b0);
    result("post_rst_def", 191, 191);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
